// File: rtl/lsu_dcache_arbiter_if.sv
// lsu_dcache_arbiter_if: L1 D-cache request/response port shared by the LSU load path and SQ drain.
interface lsu_dcache_arbiter_if #(parameter int XLEN = 64);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [XLEN-1:0] req_addr;
   logic [1:0]      req_size;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_rdata;
   modport master (output req_valid, req_we, req_addr, req_size, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata);
   modport slave  (input  req_valid, req_we, req_addr, req_size, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/lsu_dcache_arbiter.sv
// lsu_dcache_arbiter: one-outstanding arbiter of loads vs SQ drain onto the D-cache port.
// Define LSU_POSTED_STORE_EN to retire stores on the request handshake instead of the cache response.
module lsu_dcache_arbiter #(
   parameter int XLEN        = 64,
   parameter int TAG_W       = 6,
   parameter int SQ_CNT_W    = 4,
   parameter int SQ_HI_WATER = 6,
   parameter int STARVE_MAX  = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                ld_valid_i,
   output logic                ld_ready_o,
   input  logic [XLEN-1:0]     ld_addr_i,
   input  logic [1:0]          ld_size_i,
   input  logic [TAG_W-1:0]    ld_tag_i,
   input  logic                st_valid_i,
   output logic                st_ready_o,
   input  logic [XLEN-1:0]     st_addr_i,
   input  logic [1:0]          st_size_i,
   input  logic [XLEN-1:0]     st_data_i,
   input  logic [SQ_CNT_W-1:0] sq_count_i,
   lsu_dcache_arbiter_if.master dc_if,
   output logic                ld_rsp_valid_o,
   output logic [XLEN-1:0]     ld_rsp_data_o,
   output logic [TAG_W-1:0]    ld_rsp_tag_o,
   output logic                st_done_o
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             we_q, we_d;
   logic [XLEN-1:0]  addr_q, addr_d, wdata_q, wdata_d;
   logic [1:0]       size_q, size_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             force_st, grant_ld, grant_st;
   // Stores jump the queue when the SQ is nearly full or loads have hogged the port too long.
   assign force_st   = st_valid_i && (sq_count_i >= SQ_CNT_W'(SQ_HI_WATER) ||
                                      starve_q == CNT_W'(STARVE_MAX));
   assign grant_st   = (state_q == IDLE) && (force_st || (st_valid_i && !ld_valid_i));
   assign grant_ld   = (state_q == IDLE) && !force_st && ld_valid_i;
   assign ld_ready_o = grant_ld;
   assign st_ready_o = grant_st;
   assign dc_if.req_valid = (state_q == REQ);
   assign dc_if.req_we    = we_q;
   assign dc_if.req_addr  = addr_q;
   assign dc_if.req_size  = size_q;
   assign dc_if.req_wdata = wdata_q;
   assign ld_rsp_data_o   = ld_rsp_valid_o ? dc_if.rsp_rdata : '0;
   assign ld_rsp_tag_o    = ld_rsp_valid_o ? tag_q : '0;
   always_comb begin
      state_d        = state_q;
      starve_d       = starve_q;
      we_d           = we_q;
      addr_d         = addr_q;
      size_d         = size_q;
      wdata_d        = wdata_q;
      tag_d          = tag_q;
      ld_rsp_valid_o = 1'b0;
      st_done_o      = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_ld || grant_st) begin
               state_d = REQ;
               we_d    = grant_st;
               addr_d  = grant_st ? st_addr_i : ld_addr_i;
               size_d  = grant_st ? st_size_i : ld_size_i;
               wdata_d = grant_st ? st_data_i : '0;
               tag_d   = grant_st ? '0 : ld_tag_i;
            end
            // With a store waiting, IDLE always grants someone, so only a load grant keeps counting.
            starve_d = !(grant_ld && st_valid_i) ? '0 :
                       (starve_q == CNT_W'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
         end
         REQ: begin
            if (dc_if.req_ready) begin
`ifdef LSU_POSTED_STORE_EN
               state_d   = we_q ? IDLE : RSP;
               st_done_o = we_q;
`else
               state_d   = RSP;
`endif
            end
         end
         RSP: begin
            if (dc_if.rsp_valid) begin
               state_d        = IDLE;
               ld_rsp_valid_o = !we_q;
               st_done_o      = we_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         starve_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         wdata_q  <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         wdata_q  <= wdata_d;
         tag_q    <= tag_d;
      end
   end
endmodule
